// File: rtl/seg7_pkg.sv
// Shared constants for the binary-to-7-segment display path: active-low
// segment patterns (bit6=a .. bit0=g), FSM encodings and the counter width helper.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   // Counter must hold BIN_W itself, hence bin_w+1.
   function automatic int cnt_width(input int bin_w);
      return $clog2(bin_w + 1);
   endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational 4-bit BCD to active-low 7-segment decoder; blank_i or a
// non-decimal code turns the digit dark.
module seg7_digit
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bin2seg_display.sv
// Sequential double-dabble binary-to-BCD converter driving DIGITS active-low
// 7-segment displays. Define LZ_BLANK_EN to blank leading zeros on seg_out.
module bin2seg_display
   import seg7_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_out
);

   localparam int CW = cnt_width(BIN_W);

   state_t              state_q, state_d;
   logic [BIN_W-1:0]    shift_q, shift_d;
   logic [4*DIGITS-1:0] scratch_q, scratch_d, adj;
   logic                ovf_s_q, ovf_s_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic [7*DIGITS-1:0] seg_q, seg_d, dig_seg, seg_dec;
   logic [DIGITS-1:0]   blank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q   <= '0;
         scratch_q <= '0;
         ovf_s_q   <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         bcd_q     <= '0;
         seg_q     <= '1;
      end else begin
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         ovf_s_q   <= ovf_s_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         bcd_q     <= bcd_d;
         seg_q     <= seg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_SHIFT;
         ST_SHIFT: if (cnt_q == CW'(1)) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      shift_d   = shift_q;
      scratch_d = scratch_q;
      ovf_s_d   = ovf_s_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      bcd_d     = bcd_q;
      seg_d     = seg_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shift_d   = bin_in;
               scratch_d = '0;
               ovf_s_d   = 1'b0;
               cnt_d     = CW'(BIN_W);
               busy_d    = 1'b1;
            end
         end
         ST_SHIFT: begin
            // A bit leaving the top digit means the value needs more digits than we have.
            scratch_d = {adj[4*DIGITS-2:0], shift_q[BIN_W-1]};
            shift_d   = {shift_q[BIN_W-2:0], 1'b0};
            ovf_s_d   = ovf_s_q | adj[4*DIGITS-1];
            cnt_d     = cnt_q - CW'(1);
         end
         ST_LOAD: begin
            bcd_d  = scratch_q;
            seg_d  = seg_dec;
            ovf_d  = ovf_s_q;
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

`ifdef LZ_BLANK_EN
   always_comb begin
      logic lead;
      blank    = '0;
      lead     = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         lead     = lead & (scratch_q[4*i +: 4] == 4'd0);
         blank[i] = lead;
      end
   end
`else
   assign blank = '0;
`endif

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      seg7_digit u_dig (
         .bcd_i   (scratch_q[4*g +: 4]),
         .blank_i (blank[g]),
         .seg_o   (dig_seg[7*g +: 7])
      );
   end

   // Dashes win over both digits and leading-zero blanking.
   assign seg_dec = ovf_s_q ? {DIGITS{SEG_DASH}} : dig_seg;

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign bcd_out  = bcd_q;
   assign seg_out  = seg_q;

endmodule

// File: tb/tb_bin2seg_display.sv
// Bench for bin2seg_display: a 5-digit and a 4-digit instance share stimulus
// and are checked against an arithmetic decimal/segment model.
module tb_bin2seg_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] bin_in = '0;

   logic        busy_a, done_a, ovf_a;
   logic [19:0] bcd_a;
   logic [34:0] seg_a;
   logic        busy_b, done_b, ovf_b;
   logic [15:0] bcd_b;
   logic [27:0] seg_b;

   int checks = 0;
   int failures = 0;
   logic [19:0] exp_q[$];
   logic [19:0] last_bcd_a = '0;

`ifdef LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   bin2seg_display #(.BIN_W(16), .DIGITS(5)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
      .busy(busy_a), .done(done_a), .overflow(ovf_a), .bcd_out(bcd_a), .seg_out(seg_a));

   bin2seg_display #(.BIN_W(16), .DIGITS(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
      .busy(busy_b), .done(done_b), .overflow(ovf_b), .bcd_out(bcd_b), .seg_out(seg_b));

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // reference model: plain decimal arithmetic
   function automatic logic [63:0] model_bcd(input longint unsigned v, input int d);
      logic [63:0] r = '0;
      longint unsigned x = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic model_ovf(input longint unsigned v, input int d);
      longint unsigned p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return v >= p;
   endfunction

   function automatic logic [63:0] model_seg(input longint unsigned v, input int d);
      logic [63:0] r = '0;
      longint unsigned x = v;
      logic ovf = model_ovf(v, d);
      for (int i = 0; i < d; i++) begin
         if (ovf)                     r[7*i +: 7] = 7'b1111110;
         else if (LZ && i > 0 && x == 0) r[7*i +: 7] = 7'b1111111;
         else                         r[7*i +: 7] = seg_tab[x % 10];
         x = x / 10;
      end
      return r;
   endfunction

   // driver: one conversion, optionally re-pulsing start at cycle glitch_t
   task automatic convert(input logic [15:0] v, input int glitch_t, input logic [15:0] v2);
      int dones = 0;
      int done_t = -1;
      int busy_n = 0;
      logic [19:0] e;
      exp_q.push_back(model_bcd(v, 5));
      @(negedge clk);
      start = 1'b1;
      bin_in = v;
      for (int t = 0; t < 25; t++) begin
         @(negedge clk);
         start = 1'b0;
         bin_in = 16'($urandom);
         if (t == glitch_t) begin
            start = 1'b1;
            bin_in = v2;
         end
         if (busy_a) busy_n++;
         if (t == 5) chk("bcd_stable_while_busy", bcd_a, last_bcd_a);
         if (done_a) begin
            dones++;
            if (done_t < 0) begin
               done_t = t;
               e = exp_q.pop_front();
               chk("bcd_a", bcd_a, e);
               chk("ovf_a", ovf_a, model_ovf(v, 5));
               chk("seg_a", seg_a, model_seg(v, 5));
               chk("done_b_aligned", done_b, 1);
               chk("bcd_b", bcd_b, model_bcd(v, 4));
               chk("ovf_b", ovf_b, model_ovf(v, 4));
               chk("seg_b", seg_b, model_seg(v, 4));
               chk("busy_low_at_done", busy_a, 0);
               last_bcd_a = e;
            end
         end
      end
      start = 1'b0;
      chk("done_count", dones, 1);
      chk("done_latency", done_t, 17);
      chk("busy_cycles", busy_n, 17);
   endtask

   typedef struct {
      logic [15:0] v;
      logic [19:0] bcd5;
      logic        ovf5;
      logic [15:0] bcd4;
      logic        ovf4;
   } vec_t;

   vec_t tab [8];
   logic [27:0] dash4 = {4{7'b1111110}};
   int seen;

   initial begin
      tab[0] = '{16'd1234,  20'h01234, 1'b0, 16'h1234, 1'b0};
      tab[1] = '{16'd65535, 20'h65535, 1'b0, 16'h5535, 1'b1};
      tab[2] = '{16'd12345, 20'h12345, 1'b0, 16'h2345, 1'b1};
      tab[3] = '{16'd0,     20'h00000, 1'b0, 16'h0000, 1'b0};
      tab[4] = '{16'd42,    20'h00042, 1'b0, 16'h0042, 1'b0};
      tab[5] = '{16'd9999,  20'h09999, 1'b0, 16'h9999, 1'b0};
      tab[6] = '{16'd10000, 20'h10000, 1'b0, 16'h0000, 1'b1};
      tab[7] = '{16'd7,     20'h00007, 1'b0, 16'h0007, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_bcd", bcd_a, 0);
      chk("rst_seg_dark", seg_a, 35'h7FFFFFFFF);
      chk("rst_seg_b_dark", seg_b, 28'hFFFFFFF);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         convert(tab[i].v, -1, 16'd0);
         chk("tab_bcd5", bcd_a, tab[i].bcd5);
         chk("tab_ovf5", ovf_a, tab[i].ovf5);
         chk("tab_bcd4", bcd_b, tab[i].bcd4);
         chk("tab_ovf4", ovf_b, tab[i].ovf4);
         if (tab[i].v == 16'd65535) chk("seg_dig4_six", seg_a[34:28], 7'b0100000);
         if (tab[i].v == 16'd12345) chk("seg_b_all_dash", seg_b, dash4);
         if (tab[i].v == 16'd42) begin
            chk("seg42_d0", seg_a[6:0], 7'b0010010);
            chk("seg42_d1", seg_a[13:7], 7'b1001100);
            chk("seg42_hi", seg_a[34:14], LZ ? 21'h1FFFFF : {3{7'b0000001}});
         end
         if (tab[i].v == 16'd0) begin
            chk("seg0_d0", seg_a[6:0], 7'b0000001);
            chk("seg0_hi", seg_a[34:7], LZ ? 28'hFFFFFFF : {4{7'b0000001}});
         end
      end

      // start during a conversion is ignored
      convert(16'd3141, 5, 16'd2718);
      chk("ignored_start_result", bcd_a, 20'h03141);

      for (int i = 0; i < 20; i++) convert(16'($urandom_range(0, 65535)), -1, 16'd0);

      // reset mid-conversion aborts without a done pulse
      @(negedge clk);
      start = 1'b1;
      bin_in = 16'd999;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy_a, 0);
      chk("abort_bcd", bcd_a, 0);
      chk("abort_seg", seg_a, 35'h7FFFFFFFF);
      chk("abort_ovf", ovf_b, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (done_a || done_b) seen++;
      end
      chk("no_spurious_done", seen, 0);
      exp_q.delete();
      last_bcd_a = '0;
      convert(16'd7, -1, 16'd0);
      chk("after_abort_bcd", bcd_a, 20'h00007);
      chk("after_abort_seg0", seg_a[6:0], 7'b0001111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bin2seg_display.md
Name: bin2seg_display

Overview:
- Parametrised successor to the single-digit BCD-to-7-segment decoder.
- Converts a BIN_W-bit unsigned binary value into DIGITS decimal digits using a sequential double-dabble (shift/add-3) engine.
- Drives DIGITS common-anode 7-segment displays (active-low, as on the DE2-70), with a start/busy/done handshake.
- Sits between datapath counters or registers and the board HEX display pins; the display holds the last result while a new conversion runs.

Parameters:
- BIN_W, 16: width of the binary input; legal range 4..32.
- DIGITS, 5: number of decimal digits and displays driven; legal range 1..8.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle request; samples bin_in.
- bin_in, input, BIN_W: unsigned value to convert.
- busy, output, 1: high while a conversion is in progress.
- done, output, 1: one-cycle pulse when the new result is visible on the outputs.
- overflow, output, 1: last result exceeded 10^DIGITS-1; held until the next done.
- bcd_out, output, 4*DIGITS: registered BCD result; digit 0 (units) in bits [3:0].
- seg_out, output, 7*DIGITS: registered segments, active-low; per digit, bit6=a … bit0=g; digit 0 in bits [6:0].

Behaviour:
- Reset is asynchronous, active-low, one clock domain.
  - Reset values: busy=0, done=0, overflow=0, bcd_out=0, seg_out all 1s (all displays dark), FSM in IDLE.
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE: on start=1, capture bin_in into the shift register, clear the BCD scratch and the overflow scratch, load the iteration counter with BIN_W, assert busy, go to SHIFT. While start=0, stay in IDLE.
  - SHIFT: one iteration per cycle.
    - Every scratch digit >=5 gets +3, then the {scratch, shift} register shifts left by 1.
    - If a 1 shifts out of the top digit's MSB, set the overflow scratch.
    - Decrement the counter; when it reaches 1 on this cycle, go to LOAD.
  - LOAD: copy scratch to bcd_out, register the decoded segments into seg_out, copy the overflow scratch to overflow, pulse done for 1 cycle, drop busy, go to IDLE.
- Latency: start sampled at edge N; done=1 and new outputs valid in cycle N+BIN_W+1; busy high for exactly BIN_W+1 cycles.
- start while busy=1 is ignored (no queueing). start is accepted again in the cycle after done.
- Outputs bcd_out, seg_out and overflow change only in LOAD; they are stable during SHIFT.
- Segment decode per digit:
  - 0..9 use the standard active-low patterns (0 = 0000001, 8 = 0000000).
  - Codes 10..15 are blank (1111111).
- When overflow=1, every digit of seg_out shows a dash (1111110); bcd_out still holds the truncated low digits.
- Reset asserted mid-conversion aborts immediately. After release, the FSM is in IDLE with reset output values and no done pulse.
- bin_in = 0 produces a "0" on every digit (subject to the optional feature below).

Optional Feature:
- Macro: LZ_BLANK_EN.
- Defined: leading zeros are blanked (1111111) from the most significant digit downward, up to the first nonzero digit. Digit 0 is never blanked, so value 0 shows a single "0". Blanking applies to seg_out only; bcd_out is unchanged. The overflow dash display takes precedence over blanking.
- Undefined: all DIGITS digits are always shown, including leading zeros.

Decomposition:
- Shared package/include seg7_pkg:
  - segment pattern constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH;
  - FSM state encodings;
  - helper function to compute the counter width from BIN_W.
- One natural sub-module: seg7_digit, a combinational 4-bit BCD to active-low 7-segment decoder with a blank input. It is instantiated DIGITS times with a generate loop.
- The double-dabble engine and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 → seg_out all 1s, bcd_out=0, busy=0, done=0. Release, then pulse start with bin_in=1234 → after 17 cycles done=1, bcd_out=0x01234.
- BIN_W=16, DIGITS=5, bin_in=65535 → bcd_out=0x65535, overflow=0, digit 4 segments=0100000 ("6").
- DIGITS=4, bin_in=12345 → overflow=1, every digit shows 1111110, bcd_out=0x2345.
- With LZ_BLANK_EN, bin_in=42 → digits 4..2=1111111, digit 1=1001100, digit 0=0010010. bin_in=0 → only digit 0 lit (0000001).
- Pulse start again at cycle 5 of a conversion with a different bin_in → ignored; only one done pulse, and the result matches the first value.
- Drive rst_n low at cycle 8 of a conversion, release, then start with 7 → no spurious done; the next result is 0x00007, seg digit 0=0001111.
